// File: rtl/qeciphy_rx_byte_aligner.sv
// ============================================================================
// Module   : qeciphy_rx_byte_aligner
// Purpose  : Receive-path byte aligner. Searches the raw GT words for a
//            periodic 32-bit alignment word at any of four byte rotations,
//            qualifies it over several periods and emits the rotated stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module qeciphy_rx_byte_aligner #(
    parameter logic [31:0] ALIGN_WORD   = 32'hBC5A_3C96,
    parameter int          FA_PERIOD    = 1024,
    parameter int          LOCK_COUNT   = 4,
    parameter int          UNLOCK_COUNT = 4
) (
    input  logic        gt_rx_clk,
    input  logic        rst_n,
    input  logic [31:0] i_gt_rx_data,
    input  logic        i_realign,
    output logic [31:0] o_rx_data,
    output logic [1:0]  o_byte_offset,
    output logic        o_locked,
    output logic        o_lock_lost
);

    localparam int               POS_W    = $clog2(FA_PERIOD);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FA_PERIOD - 1);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_COUNT);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      data_q;
    logic [63:0]      window;
    logic [31:0]      cand [4];
    logic [3:0]       cand_match;
    logic [1:0]       first_k;
    logic [1:0]       offset;
    logic [1:0]       offset_nxt;
    logic [3:0]       hits;
    logic [3:0]       hits_nxt;
    logic [3:0]       misses;
    logic [3:0]       misses_nxt;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nxt;
    logic             detect;
    logic             slot;
    logic             unlock;
    logic             locked_nxt;
    logic             lost_nxt;
    logic [31:0]      rx_data_nxt;

    // The previous word completes the 64-bit window that all rotations draw from
    assign window = {i_gt_rx_data, data_q};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_cand
            assign cand[k]       = window[8*k +: 32];
            assign cand_match[k] = (cand[k] == ALIGN_WORD);
        end
    endgenerate

    // A fresh detection is only possible while searching and not being forced to re-search
    assign detect = (state == ST_SEARCH) && !i_realign && (|cand_match);
    // Expected slot: the position where a qualified alignment word must reappear
    assign slot   = (pos == '0) && (state != ST_SEARCH);

    // Pick the lowest rotation that currently matches the alignment word
    always_comb begin
        first_k = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (cand_match[k]) begin
                first_k = 2'(k);
            end
        end
    end

    // State register with hit/miss counters and selected rotation
    always_ff @(posedge gt_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_SEARCH;
            offset <= 2'd0;
            hits   <= 4'd0;
            misses <= 4'd0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            hits   <= hits_nxt;
            misses <= misses_nxt;
        end
    end

    // Next-state logic: search, qualify over several periods, track misses once locked
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        hits_nxt   = hits;
        misses_nxt = misses;
        unlock     = 1'b0;
        if (i_realign) begin
            // Re-search request wins over any concurrent hit, lock or loss event
            state_nxt  = ST_SEARCH;
            hits_nxt   = 4'd0;
            misses_nxt = 4'd0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (detect) begin
                        offset_nxt = first_k;
                        hits_nxt   = 4'd1;
                        misses_nxt = 4'd0;
                        state_nxt  = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (slot) begin
                        if (cand_match[offset]) begin
                            hits_nxt = hits + 4'd1;
                            if ((hits + 4'd1) >= LOCK_N) begin
                                state_nxt  = ST_LOCKED;
                                misses_nxt = 4'd0;
                            end
                        end else begin
                            state_nxt = ST_SEARCH;
                            hits_nxt  = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (slot) begin
                        if (cand_match[offset]) begin
                            misses_nxt = 4'd0;
                        end else if ((misses + 4'd1) >= UNLOCK_N) begin
                            state_nxt  = ST_SEARCH;
                            hits_nxt   = 4'd0;
                            misses_nxt = 4'd0;
                            unlock     = 1'b1;
                        end else begin
                            misses_nxt = misses + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt  = ST_SEARCH;
                    hits_nxt   = 4'd0;
                    misses_nxt = 4'd0;
                end
            endcase
        end
    end

    // Output decode; the rotation used this cycle already reflects a new detection
    always_comb begin
        locked_nxt  = (state_nxt == ST_LOCKED);
        lost_nxt    = unlock;
        rx_data_nxt = cand[offset_nxt];
        pos_nxt     = (pos == POS_LAST) ? '0 : pos + 1'b1;
        if (detect) begin
            pos_nxt = POS_W'(1);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge gt_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= 32'd0;
            pos         <= '0;
            o_rx_data   <= 32'd0;
            o_locked    <= 1'b0;
            o_lock_lost <= 1'b0;
        end else begin
            data_q      <= i_gt_rx_data;
            pos         <= pos_nxt;
            o_rx_data   <= rx_data_nxt;
            o_locked    <= locked_nxt;
            o_lock_lost <= lost_nxt;
        end
    end

    assign o_byte_offset = offset;

endmodule

`default_nettype wire

// File: tb/tb_qeciphy_rx_byte_aligner.sv
// ============================================================================
// Module   : tb_qeciphy_rx_byte_aligner
// Purpose  : Directed self-checking bench for the receive byte aligner:
//            default-parameter instance plus a FA_PERIOD=4 / LOCK_COUNT=1 one.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qeciphy_rx_byte_aligner;

    localparam logic [31:0] AW  = 32'hBC5A_3C96;
    localparam logic [31:0] BAD = 32'hBC5A_3D96;
    localparam int          P   = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_m;
    logic        realign_m;
    logic [31:0] rx_m;
    logic [1:0]  off_m;
    logic        locked_m;
    logic        lost_m;
    logic [31:0] data_c;
    logic        realign_c;
    logic [31:0] rx_c;
    logic [1:0]  off_c;
    logic        locked_c;
    logic        lost_c;

    int          checks = 0;
    int          fails  = 0;
    int          k0;
    logic [31:0] a_prev;

    always #5 clk = ~clk;

    qeciphy_rx_byte_aligner dut (
        .gt_rx_clk     (clk),
        .rst_n         (rst_n),
        .i_gt_rx_data  (data_m),
        .i_realign     (realign_m),
        .o_rx_data     (rx_m),
        .o_byte_offset (off_m),
        .o_locked      (locked_m),
        .o_lock_lost   (lost_m)
    );

    qeciphy_rx_byte_aligner #(
        .FA_PERIOD  (4),
        .LOCK_COUNT (1)
    ) dut_c (
        .gt_rx_clk     (clk),
        .rst_n         (rst_n),
        .i_gt_rx_data  (data_c),
        .i_realign     (realign_c),
        .o_rx_data     (rx_c),
        .o_byte_offset (off_c),
        .o_locked      (locked_c),
        .o_lock_lost   (lost_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one transmitter-aligned word, presented to the main DUT rotated by k0 bytes
    task automatic send(input logic [31:0] a);
        logic [63:0] w;
        w      = {a, a_prev} >> (32 - 8 * k0);
        data_m = w[31:0];
        a_prev = a;
        tick();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) send($urandom);
    endtask

    // Alignment (or corrupted) word followed by the word whose edge evaluates it
    task automatic frame(input bit good, input bit rl);
        send(good ? AW : BAD);
        realign_m = rl;
        send($urandom);
        realign_m = 1'b0;
    endtask

    task automatic period(input bit good, input bit rl);
        fill(P - 2);
        frame(good, rl);
    endtask

    initial begin
        rst_n     = 1'b0;
        data_m    = 32'd0;
        data_c    = 32'd0;
        realign_m = 1'b0;
        realign_c = 1'b0;
        k0        = 0;
        a_prev    = 32'd0;
        repeat (2) tick();
        chk("reset_rx_data",  rx_m, 32'd0);
        chk("reset_offset",   32'(off_m), 32'd0);
        chk("reset_locked",   32'(locked_m), 32'd0);
        chk("reset_lost",     32'(lost_m), 32'd0);
        chk("reset_c_locked", 32'(locked_c), 32'd0);
        rst_n = 1'b1;
        tick();

        // Corner instance: lock on the first detection, slot every 4 words
        data_c = $urandom; tick();
        data_c = $urandom; tick();
        data_c = AW;       tick();
        data_c = $urandom; tick();
        chk("c_locked_first", 32'(locked_c), 32'd1);
        chk("c_rx_first",     rx_c, AW);
        chk("c_offset",       32'(off_c), 32'd0);
        for (int p = 0; p < 2; p++) begin
            data_c = $urandom; tick();
            data_c = $urandom; tick();
            data_c = AW;       tick();
            data_c = $urandom; tick();
            chk("c_locked_hold", 32'(locked_c), 32'd1);
            chk("c_rx_align",    rx_c, AW);
        end
        for (int p = 0; p < 4; p++) begin
            repeat (4) begin
                data_c = $urandom;
                tick();
            end
            if (p < 3) begin
                chk("c_miss_locked", 32'(locked_c), 32'd1);
                chk("c_miss_nolost", 32'(lost_c), 32'd0);
            end else begin
                chk("c_lost_pulse",  32'(lost_c), 32'd1);
                chk("c_lost_locked", 32'(locked_c), 32'd0);
            end
        end
        data_c = $urandom; tick();
        chk("c_lost_one_cycle", 32'(lost_c), 32'd0);

        // Clean lock at rotation 2
        k0 = 2;
        fill(5);
        frame(1'b1, 1'b0);
        chk("lock2_offset",  32'(off_m), 32'd2);
        chk("lock2_rx",      rx_m, AW);
        chk("lock2_locked1", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("lock2_rx2",     rx_m, AW);
        chk("lock2_locked2", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("lock2_locked3", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("lock2_locked4", 32'(locked_m), 32'd1);
        chk("lock2_rx4",     rx_m, AW);

        // Misses below the threshold, a recovering hit, then a loss of lock
        for (int i = 0; i < 3; i++) begin
            period(1'b0, 1'b0);
            chk("miss3_locked", 32'(locked_m), 32'd1);
        end
        period(1'b1, 1'b0);
        chk("recover_locked", 32'(locked_m), 32'd1);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        period(1'b1, 1'b0);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        chk("pattern_locked", 32'(locked_m), 32'd1);
        chk("pattern_nolost", 32'(lost_m), 32'd0);
        period(1'b0, 1'b0);
        chk("loss_pulse",  32'(lost_m), 32'd1);
        chk("loss_locked", 32'(locked_m), 32'd0);
        chk("loss_offset", 32'(off_m), 32'd2);
        fill(1);
        chk("loss_one_cycle", 32'(lost_m), 32'd0);

        // Confirm failure at rotation 1 with a spurious match at pos 500
        k0 = 1;
        fill(5);
        frame(1'b1, 1'b0);
        chk("cf_offset", 32'(off_m), 32'd1);
        fill(498);
        frame(1'b1, 1'b0);
        chk("cf_spurious_offset", 32'(off_m), 32'd1);
        chk("cf_spurious_locked", 32'(locked_m), 32'd0);
        fill(522);
        frame(1'b0, 1'b0);
        chk("cf_fail_locked", 32'(locked_m), 32'd0);

        // Back in search: a rotation-3 stream is picked up and locks
        k0 = 3;
        fill(5);
        frame(1'b1, 1'b0);
        chk("lock3_offset", 32'(off_m), 32'd3);
        period(1'b1, 1'b0);
        period(1'b1, 1'b0);
        chk("lock3_locked3", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("lock3_locked4", 32'(locked_m), 32'd1);

        // Realign coincident with an expected-slot match
        period(1'b1, 1'b1);
        chk("realign_locked", 32'(locked_m), 32'd0);
        chk("realign_nolost", 32'(lost_m), 32'd0);
        chk("realign_offset", 32'(off_m), 32'd3);

        // Re-lock at rotation 0
        k0 = 0;
        fill(5);
        frame(1'b1, 1'b0);
        chk("lock0_offset",  32'(off_m), 32'd0);
        chk("lock0_rx",      rx_m, AW);
        period(1'b1, 1'b0);
        period(1'b1, 1'b0);
        chk("lock0_locked3", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("lock0_locked4", 32'(locked_m), 32'd1);

        // Asynchronous reset while locked, then a fresh qualification
        fill(100);
        rst_n = 1'b0;
        #1;
        chk("arst_locked",  32'(locked_m), 32'd0);
        chk("arst_offset",  32'(off_m), 32'd0);
        chk("arst_rx_data", rx_m, 32'd0);
        chk("arst_lost",    32'(lost_m), 32'd0);
        tick();
        rst_n = 1'b1;
        k0    = 2;
        fill(5);
        frame(1'b1, 1'b0);
        chk("rl_offset",  32'(off_m), 32'd2);
        chk("rl_locked1", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        period(1'b1, 1'b0);
        chk("rl_locked3", 32'(locked_m), 32'd0);
        period(1'b1, 1'b0);
        chk("rl_locked4", 32'(locked_m), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
